mem_port_arbiter: RTL and testbench

Shares the single-ported unified RAM between the IF-stage instruction fetch and the MEM-stage load/store unit of the 5-stage MIPS pipeline. Arbitrates requests, sequences each access through a small FSM, and converts partial (byte/halfword) stores into read-modify-write word accesses, because the RAM only writes full words. Sits between the pipeline stage ports and the RAM's `write_enable`/`write_address`/`write_data`/`read_address`/`read_data` pins.

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 169 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side request/response ports and RAM pins of mem_port_arbiter.
// slave is the arbiter's view; master is the pipeline/RAM environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DATA_SIZE    = 32
);
    logic                    if_req;
    logic [ADDRESS_SIZE-1:0] if_addr;
    logic                    if_gnt;
    logic                    if_rvalid;
    logic [DATA_SIZE-1:0]    if_rdata;

    logic                    dm_req;
    logic                    dm_we;
    logic [3:0]              dm_be;
    logic [ADDRESS_SIZE-1:0] dm_addr;
    logic [DATA_SIZE-1:0]    dm_wdata;
    logic                    dm_gnt;
    logic                    dm_rvalid;
    logic [DATA_SIZE-1:0]    dm_rdata;

    logic                    ram_we;
    logic [ADDRESS_SIZE-1:0] ram_waddr;
    logic [DATA_SIZE-1:0]    ram_wdata;
    logic [ADDRESS_SIZE-1:0] ram_raddr;
    logic [DATA_SIZE-1:0]    ram_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, ram_rdata,
        output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               ram_we, ram_waddr, ram_wdata, ram_raddr
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata, ram_rdata,
        input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
               ram_we, ram_waddr, ram_wdata, ram_raddr
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported word RAM between instruction fetch and the load/store unit,
// turning partial stores into read-modify-write. Define MEM_ARB_STARVE_GUARD_EN for the IF starvation guard.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDRESS_SIZE = 32,
    parameter int unsigned DATA_SIZE    = 32
) (
    input  logic             clk,
    input  logic             reset,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned AW = ADDRESS_SIZE;
    localparam int unsigned DW = DATA_SIZE;

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] IF_RD  = 3'd1;
    localparam logic [2:0] DM_RD  = 3'd2;
    localparam logic [2:0] DM_WR  = 3'd3;
    localparam logic [2:0] RMW_RD = 3'd4;
    localparam logic [2:0] RMW_WR = 3'd5;

    // Byte lanes are fixed at four and the guard counter is 4 bits wide.
    if (DW != 32 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_cfg
        $error("mem_port_arbiter: DATA_SIZE must be 32 and STARVE_LIMIT in 1..15");
    end

    logic [2:0]    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d, raddr_q, raddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
    logic          if_rvalid_q, if_rvalid_d, dm_rvalid_q, dm_rvalid_d;
    logic          if_gnt_c, dm_gnt_c, ram_we_c, starve_hit_c;
    logic [AW-1:0] dm_al_c, if_al_c;
    logic [DW-1:0] merged_c;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt_q, starve_cnt_d;
    assign starve_hit_c = bus.if_req && (starve_cnt_q == 4'(STARVE_LIMIT));
`else
    assign starve_hit_c = 1'b0;
`endif

    assign dm_al_c = bus.dm_addr & ~AW'(3);
    assign if_al_c = bus.if_addr & ~AW'(3);

    // Enabled lanes take store data, the rest keep the word read back from RAM.
    always_comb begin
        merged_c = bus.ram_rdata;
        for (int i = 0; i < 4; i++) begin
            if (be_q[i]) merged_c[8*i +: 8] = wdata_q[8*i +: 8];
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        raddr_d     = raddr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        dm_rdata_d  = dm_rdata_q;
        if_rvalid_d = 1'b0;
        dm_rvalid_d = 1'b0;
        if_gnt_c    = 1'b0;
        dm_gnt_c    = 1'b0;
        ram_we_c    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.dm_req && !starve_hit_c) begin
                    dm_gnt_c = 1'b1;
                    addr_d   = dm_al_c;
                    be_d     = bus.dm_be;
                    wdata_d  = bus.dm_wdata;
                    if (!bus.dm_we) begin
                        state_d = DM_RD;
                        raddr_d = dm_al_c;
                    end else if (bus.dm_be == 4'hF) begin
                        state_d = DM_WR;
                    end else if (bus.dm_be != 4'h0) begin
                        state_d = RMW_RD;
                        raddr_d = dm_al_c;
                    end else begin
                        dm_rvalid_d = 1'b1;
                        dm_rdata_d  = DW'(0);
                    end
                end else if (bus.if_req) begin
                    if_gnt_c = 1'b1;
                    addr_d   = if_al_c;
                    raddr_d  = if_al_c;
                    state_d  = IF_RD;
                end
            end
            IF_RD: begin
                if_rdata_d  = bus.ram_rdata;
                if_rvalid_d = 1'b1;
                state_d     = IDLE;
            end
            DM_RD: begin
                dm_rdata_d  = bus.ram_rdata;
                dm_rvalid_d = 1'b1;
                state_d     = IDLE;
            end
            RMW_RD: begin
                wdata_d = merged_c;
                state_d = RMW_WR;
            end
            DM_WR, RMW_WR: begin
                ram_we_c    = 1'b1;
                dm_rvalid_d = 1'b1;
                dm_rdata_d  = DW'(0);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Nothing is granted or written while reset is asserted.
        if (reset) begin
            if_gnt_c = 1'b0;
            dm_gnt_c = 1'b0;
            ram_we_c = 1'b0;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        starve_cnt_d = starve_cnt_q;
        if (if_gnt_c) starve_cnt_d = 4'd0;
        else if (dm_gnt_c && bus.if_req) starve_cnt_d = starve_cnt_q + 4'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= AW'(0);
            raddr_q     <= AW'(0);
            be_q        <= 4'd0;
            wdata_q     <= DW'(0);
            if_rdata_q  <= DW'(0);
            dm_rdata_q  <= DW'(0);
            if_rvalid_q <= 1'b0;
            dm_rvalid_q <= 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            raddr_q     <= raddr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            dm_rdata_q  <= dm_rdata_d;
            if_rvalid_q <= if_rvalid_d;
            dm_rvalid_q <= dm_rvalid_d;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve_cnt_q <= starve_cnt_d;
`endif
        end
    end

    assign bus.if_gnt    = if_gnt_c;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.dm_gnt    = dm_gnt_c;
    assign bus.dm_rvalid = dm_rvalid_q;
    assign bus.dm_rdata  = dm_rdata_q;
    assign bus.ram_we    = ram_we_c;
    assign bus.ram_waddr = addr_q;
    assign bus.ram_wdata = wdata_q;
    assign bus.ram_raddr = raddr_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: drivers push expected responses from a word-level
// memory model at grant time; a monitor pops and compares on every rvalid pulse.
module tb_mem_port_arbiter;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned WORDS = 256;

    typedef struct {
        logic [31:0] data;
        int unsigned due;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    bit   ram_init = 1'b1;

    mem_port_arbiter_if #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) bus ();

    mem_port_arbiter #(.STARVE_LIMIT(4), .ADDRESS_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    exp_t        if_q[$];
    exp_t        dm_q[$];
    logic [31:0] tb_ram [WORDS];
    logic [31:0] ref_mem[WORDS];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fails = 0;
    int          we_cycles = 0;
    logic [31:0] last_if = '0;
    logic [31:0] last_dm = '0;
    bit          log_en = 1'b0;
    string       gnt_log = "";

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        if (i == 128) return 32'h1122_3344;
        if (i == 192) return 32'h0000_0055;
        return 32'h0F1E_2D3C ^ (32'(i) * 32'h0100_0193);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // Behavioural single-port RAM: combinational read, write at the clock edge.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < WORDS; i++) tb_ram[i] <= init_word(i);
        end else if (bus.ram_we === 1'b1) begin
            tb_ram[bus.ram_waddr[9:2]] <= bus.ram_wdata;
        end
    end
    assign bus.ram_rdata = tb_ram[bus.ram_raddr[9:2]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_str(input string name, input string act, input string exp);
        n_checks++;
        if (act != exp) begin
            n_fails++;
            $display("FAIL %s: got %s expected %s", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_fails++;
        $display("FAIL %s: event did not happen as required (t=%0t)", name, $time);
    endtask

    // Monitor: every response must match the oldest outstanding expectation, on time.
    always @(negedge clk) begin
        exp_t e;
        check("ram_we_known", 32'($isunknown(bus.ram_we)), 32'd0);
        if (bus.ram_we === 1'b1) we_cycles++;
        if (!reset && !ram_init) begin
            if (bus.if_rvalid === 1'b1) begin
                if (if_q.size() == 0) fail("if_rvalid_unexpected");
                else begin
                    e = if_q.pop_front();
                    check("if_rdata", bus.if_rdata, e.data);
                    check("if_latency", cyc, e.due);
                end
                last_if = bus.if_rdata;
            end
            if (bus.dm_rvalid === 1'b1) begin
                if (dm_q.size() == 0) fail("dm_rvalid_unexpected");
                else begin
                    e = dm_q.pop_front();
                    check("dm_rdata", bus.dm_rdata, e.data);
                    check("dm_latency", cyc, e.due);
                end
                last_dm = bus.dm_rdata;
            end
        end
    end

    // Called at a falling edge; returns at the falling edge after the grant.
    task automatic dm_op(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wdata);
        int   w;
        bit   got;
        exp_t e;
        logic [31:0] m;
        got = 1'b0;
        w = int'(addr[9:2]);
        bus.dm_req = 1'b1; bus.dm_we = we; bus.dm_be = be;
        bus.dm_addr = addr; bus.dm_wdata = wdata;
        for (int t = 0; t < 200 && !got; t++) begin
            #1;
            if (bus.dm_gnt === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) fail("dm_gnt_timeout");
        else begin
            if (log_en) gnt_log = {gnt_log, "D"};
            m = lane_mask(be);
            if (!we) e = '{ref_mem[w], cyc + 2};
            else if (be == 4'hF) begin ref_mem[w] = wdata; e = '{32'd0, cyc + 2}; end
            else if (be != 4'h0) begin
                ref_mem[w] = (ref_mem[w] & ~m) | (wdata & m);
                e = '{32'd0, cyc + 3};
            end else e = '{32'd0, cyc + 1};
            dm_q.push_back(e);
            @(negedge clk);
        end
        bus.dm_req = 1'b0;
    endtask

    task automatic if_op(input logic [31:0] addr);
        bit got;
        got = 1'b0;
        bus.if_req = 1'b1; bus.if_addr = addr;
        for (int t = 0; t < 200 && !got; t++) begin
            #1;
            if (bus.if_gnt === 1'b1) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) fail("if_gnt_timeout");
        else begin
            if (log_en) gnt_log = {gnt_log, "I"};
            if_q.push_back('{ref_mem[int'(addr[9:2])], cyc + 2});
            @(negedge clk);
        end
        bus.if_req = 1'b0;
    endtask

    task automatic drain();
        for (int t = 0; t < 100 && (if_q.size() != 0 || dm_q.size() != 0); t++) @(negedge clk);
        if (if_q.size() != 0 || dm_q.size() != 0) fail("drain_timeout");
        if_q.delete();
        dm_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0;
        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        reset = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.dm_be = 4'hF;
        bus.dm_addr = 32'h104; bus.dm_wdata = 32'h0;
        @(negedge clk);
        ram_init = 1'b0;

        // Reset with both requesting: everything quiet.
        for (int c = 0; c < 3; c++) begin
            #1;
            check("rst_if_gnt", 32'(bus.if_gnt), 32'd0);
            check("rst_dm_gnt", 32'(bus.dm_gnt), 32'd0);
            if (c == 0) begin
                check("rst_ram_we", 32'(bus.ram_we), 32'd0);
                check("rst_if_rvalid", 32'(bus.if_rvalid), 32'd0);
                check("rst_dm_rvalid", 32'(bus.dm_rvalid), 32'd0);
                check("rst_if_rdata", bus.if_rdata, 32'd0);
                check("rst_dm_rdata", bus.dm_rdata, 32'd0);
                check("rst_ram_waddr", bus.ram_waddr, 32'd0);
                check("rst_ram_wdata", bus.ram_wdata, 32'd0);
                check("rst_ram_raddr", bus.ram_raddr, 32'd0);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        #1;
        check("first_gnt_dm", 32'(bus.dm_gnt), 32'd1);
        check("first_gnt_not_if", 32'(bus.if_gnt), 32'd0);
        // Abandon that load with a reset; no response may appear.
        @(negedge clk);
        reset = 1'b1; bus.if_req = 1'b0; bus.dm_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // Full store then fetch of the same word.
        we0 = we_cycles;
        dm_op(1'b1, 4'hF, 32'h100, 32'hDEAD_BEEF);
        if_op(32'h100);
        drain();
        check("full_store_we_cycles", 32'(we_cycles - we0), 32'd1);
        check("fetch_after_store", last_if, 32'hDEAD_BEEF);

        // Partial store merges into the preloaded word.
        we0 = we_cycles;
        dm_op(1'b1, 4'b0100, 32'h200, 32'h00AA_0000);
        dm_op(1'b0, 4'hF, 32'h200, 32'h0);
        drain();
        check("rmw_we_cycles", 32'(we_cycles - we0), 32'd1);
        check("rmw_result", last_dm, 32'h11AA_3344);

        // Unaligned load reads the containing word.
        dm_op(1'b0, 4'hF, 32'h103, 32'h0);
        #1;
        check("unaligned_raddr", bus.ram_raddr, 32'h100);
        @(negedge clk);
        drain();
        check("unaligned_rdata", last_dm, 32'hDEAD_BEEF);

        // Reset during the write cycle of a full store.
        bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_be = 4'hF;
        bus.dm_addr = 32'h300; bus.dm_wdata = 32'hCAFE_F00D;
        #1;
        check("rst_wr_gnt", 32'(bus.dm_gnt), 32'd1);
        @(negedge clk);
        bus.dm_req = 1'b0;
        reset = 1'b1;
        #1;
        check("rst_wr_ram_we", 32'(bus.ram_we), 32'd0);
        @(negedge clk);
        check("rst_wr_no_rvalid", 32'(bus.dm_rvalid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        dm_op(1'b0, 4'hF, 32'h300, 32'h0);
        drain();
        check("rst_wr_word_kept", last_dm, 32'h0000_0055);

        // Both requesting continuously.
        do_reset();
        log_en = 1'b1;
        gnt_log = "";
        fork
            begin
                for (int k = 0; k < 8; k++) dm_op(1'b0, 4'hF, 32'(k * 4), 32'h0);
            end
            begin
                for (int k = 0; k < 2; k++) if_op(32'h40 + 32'(k * 4));
            end
        join
        drain();
        log_en = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
        check_str("grant_sequence", gnt_log, "DDDDIDDDDI");
`else
        check_str("grant_sequence", gnt_log, "DDDDDDDDII");
`endif

        // Randomised mixed traffic.
        fork
            begin
                for (int k = 0; k < 60; k++) begin
                    logic [3:0] be;
                    int sel;
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    sel = int'($urandom_range(0, 3));
                    be  = (sel == 1) ? 4'hF : (sel == 3) ? 4'h0 : 4'($urandom);
                    dm_op(sel != 0, be, 32'($urandom_range(0, 1023)), $urandom);
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    if_op(32'($urandom_range(0, 1023)));
                end
            end
        join
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
